// File: rtl/upsample2x2_pkg.sv
// Shared parameters for the 2x nearest-neighbour upsampler: pixel width,
// FSM state encoding and a counter-width helper.
package upsample2x2_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        ST_TOP = 1'b0,
        ST_BOT = 1'b1
    } state_t;

    // A one-pixel row still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/upsample2x2_if.sv
// Pixel stream interface: pooled pixels in (valid/ready), upsampled pixels out
// (valid only, no backpressure).
interface upsample2x2_if;
    import upsample2x2_pkg::*;

    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    modport master (
        output valid_in,
        output data,
        input  in_ready,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  valid_in,
        input  data,
        output in_ready,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/upsample2x2_lines_buffer.sv
// Single-row pixel store: synchronous write, asynchronous read. Written while
// the top row is emitted, read back while the bottom row is replayed.
module lines_buffer_upsample
    import upsample2x2_pkg::*;
#(
    parameter int HALF = 2,
    parameter int AW   = cnt_width(HALF),
    parameter int DW   = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [HALF];

    // Contents are never read before being rewritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/upsample2x2.sv
// Streaming 2x nearest-neighbour upsampler: each accepted pixel is emitted twice
// on the top output row, then the buffered row is replayed as the bottom row.
module upsample2x2
    import upsample2x2_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    upsample2x2_if.slave  s
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = cnt_width(HALF);
    localparam logic [CW-1:0] COL_LAST = CW'(HALF - 1);

    state_t                state_q, state_d;
    logic                  ph_q, ph_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         bcol_q, bcol_d;
    logic                  bph_q, bph_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    logic                  buf_we;
    logic [DATA_WIDTH-1:0] buf_rdata;

    lines_buffer_upsample #(
        .HALF (HALF),
        .AW   (CW),
        .DW   (DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (col_q),
        .wdata (s.data),
        .raddr (bcol_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_TOP;
            ph_q        <= 1'b0;
            col_q       <= '0;
            bcol_q      <= '0;
            bph_q       <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            col_q       <= col_d;
            bcol_q      <= bcol_d;
            bph_q       <= bph_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        col_d       = col_q;
        bcol_d      = bcol_q;
        bph_d       = bph_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            ST_TOP: begin
                if (!ph_q) begin
                    if (s.valid_in) begin
                        data_out_d  = s.data;
                        valid_out_d = 1'b1;
                        buf_we      = 1'b1;
                        ph_d        = 1'b1;
                    end
                end else begin
                    // Second copy: data_out simply holds its value.
                    valid_out_d = 1'b1;
                    ph_d        = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_BOT;
                        bcol_d  = '0;
                        bph_d   = 1'b0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_BOT: begin
                data_out_d  = buf_rdata;
                valid_out_d = 1'b1;
                bph_d       = ~bph_q;
                if (bph_q) begin
                    if (bcol_q == COL_LAST) begin
                        bcol_d  = '0;
                        state_d = ST_TOP;
                        ph_d    = 1'b0;
                    end else begin
                        bcol_d = bcol_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_TOP;
        endcase
    end

    assign s.in_ready  = (state_q == ST_TOP) && !ph_q;
    assign s.data_out  = data_out_q;
    assign s.valid_out = valid_out_q;

endmodule

// File: tb/tb_upsample2x2.sv
// Directed bench for upsample2x2 (WIDTH=4): a cycle table of inputs and
// hand-derived in_ready/valid_out/data_out values, plus a mid-replay reset.
module tb_upsample2x2;
    import upsample2x2_pkg::*;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    typedef struct {
        logic vin;   // valid_in driven for the coming edge
        pix_t din;
        logic er;    // expected in_ready this cycle
        logic ev;    // expected valid_out this cycle
        pix_t ed;    // expected data_out
        logic cd;    // compare data_out even when ev=0
        logic ar;    // pulse reset after this row's checks
    } vec_t;

    localparam pix_t A  = 8'h11, B  = 8'h22, C  = 8'h33, D  = 8'h44;
    localparam pix_t E  = 8'h55, F  = 8'h66, G  = 8'h77, H  = 8'h88;
    localparam pix_t E2 = 8'hA5, F2 = 8'h5A, JUNK = 8'hEE;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    upsample2x2_if bus ();

    upsample2x2 #(.WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic vin, input pix_t din, input logic er, input logic ev,
                       input pix_t ed, input logic cd, input logic ar);
        vec_t v;
        v.vin = vin; v.din = din; v.er = er; v.ev = ev; v.ed = ed; v.cd = cd; v.ar = ar;
        vecs.push_back(v);
    endtask

    initial begin
        // Row A,B with valid high, then C held through ph=1 and BOT (stall),
        // then D: 16 contiguous beats AABBAABBCCDDCCDD.
        add(1, A, 1, 0, 0, 1, 0);
        add(1, B, 0, 1, A, 0, 0);
        add(1, B, 1, 1, A, 0, 0);
        add(1, C, 0, 1, B, 0, 0);
        add(1, C, 0, 1, B, 0, 0);
        add(1, C, 0, 1, A, 0, 0);
        add(1, C, 0, 1, A, 0, 0);
        add(1, C, 0, 1, B, 0, 0);
        add(1, C, 1, 1, B, 0, 0);
        add(1, D, 0, 1, C, 0, 0);
        add(1, D, 1, 1, C, 0, 0);
        add(0, 0, 0, 1, D, 0, 0);
        add(0, 0, 0, 1, D, 0, 0);
        add(0, 0, 0, 1, C, 0, 0);
        add(0, 0, 0, 1, C, 0, 0);
        add(0, 0, 0, 1, D, 0, 0);
        add(0, 0, 1, 1, D, 0, 0);
        // Gapped: G, three idle ph=0 cycles, H, then contiguous replay.
        add(1, G, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, G, 0, 0);
        add(0, 0, 1, 1, G, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(1, H, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, H, 0, 0);
        add(0, 0, 0, 1, H, 0, 0);
        add(0, 0, 0, 1, G, 0, 0);
        add(0, 0, 0, 1, G, 0, 0);
        add(0, 0, 0, 1, H, 0, 0);
        // Row E,F, reset after two replay beats.
        add(1, E, 1, 1, H, 0, 0);
        add(1, F, 0, 1, E, 0, 0);
        add(1, F, 1, 1, E, 0, 0);
        add(0, 0, 0, 1, F, 0, 0);
        add(0, 0, 0, 1, F, 0, 0);
        add(0, 0, 0, 1, E, 0, 0);
        add(1, JUNK, 0, 1, E, 0, 1);
        // Fresh row after reset: no stale buffer data may appear.
        add(1, E2, 1, 0, 0, 1, 0);
        add(1, F2, 0, 1, E2, 0, 0);
        add(1, F2, 1, 1, E2, 0, 0);
        add(0, 0, 0, 1, F2, 0, 0);
        add(0, 0, 0, 1, F2, 0, 0);
        add(0, 0, 0, 1, E2, 0, 0);
        add(0, 0, 0, 1, E2, 0, 0);
        add(0, 0, 0, 1, F2, 0, 0);
        add(0, 0, 1, 1, F2, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);

        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.data     = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_vout", 32'(bus.valid_out), 32'd0);
        check_val("reset_dout", 32'(bus.data_out), 32'd0);
        check_val("reset_rdy", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;

        foreach (vecs[i]) begin
            $display("cyc %0d: vin=%0b din=%h | rdy=%0b vout=%0b dout=%h",
                     i, vecs[i].vin, vecs[i].din, bus.in_ready, bus.valid_out, bus.data_out);
            check_val($sformatf("rdy[%0d]", i), 32'(bus.in_ready), 32'(vecs[i].er));
            check_val($sformatf("vout[%0d]", i), 32'(bus.valid_out), 32'(vecs[i].ev));
            if (vecs[i].ev || vecs[i].cd)
                check_val($sformatf("dout[%0d]", i), 32'(bus.data_out), 32'(vecs[i].ed));
            bus.valid_in = vecs[i].vin;
            bus.data     = vecs[i].din;
            if (vecs[i].ar) begin
                rst = 1'b0;
                #1;
                check_val("midrst_vout", 32'(bus.valid_out), 32'd0);
                check_val("midrst_dout", 32'(bus.data_out), 32'd0);
                check_val("midrst_rdy", 32'(bus.in_ready), 32'd1);
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
